chunk_subtractor: RTL and testbench
===================================

CHUNK_SUBTRACTOR -- requirements
Module: chunk_subtractor

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 Parameter CHUNK, default 8: bits processed per cycle; WIDTH SHALL be an integer multiple of CHUNK, with CHUNK <= WIDTH.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 a_in  input  WIDTH  minuend.
REQ-006 b_in  input  WIDTH  subtrahend.
REQ-007 bw_in  input  1  borrow in.
REQ-008 in_valid  input  1  operands valid.
REQ-009 in_ready  output  1  block can accept operands.
REQ-010 diff_out  output  WIDTH  a_in - b_in - bw_in, modulo 2^WIDTH.
REQ-011 bw_out  output  1  borrow out: 1 iff a_in < b_in + bw_in (unsigned).
REQ-012 ovf_out  output  1  two's-complement signed overflow of the subtraction.
REQ-013 out_valid  output  1  result valid.
REQ-014 out_ready  input  1  downstream accepts result.

Function
REQ-015 FSM states SHALL be IDLE, CALC and DONE; N = WIDTH/CHUNK.
REQ-016 in_ready SHALL be 1 exactly in IDLE; out_valid SHALL be 1 exactly in DONE.
REQ-017 Accept = in_valid & in_ready at a rising edge; on accept, the block SHALL register a_in, b_in and bw_in, clear the chunk counter, and go to CALC.
REQ-018 Operand inputs SHALL be ignored at all edges other than the accept edge.
REQ-019 Each CALC edge SHALL compute one CHUNK-bit slice, LSB slice first: slice k = a[k] - b[k] - borrow, with borrow seeded by registered bw_in at k=0 and propagated between slices.
REQ-020 After the N-th CALC edge, the FSM SHALL enter DONE, with diff_out, bw_out and ovf_out final.
REQ-021 Latency: out_valid SHALL rise N+1 rising edges after the accept edge (5 for default parameters).
REQ-022 bw_out SHALL equal the borrow out of the MSB slice.
REQ-023 ovf_out SHALL be 1 iff a[WIDTH-1] != b[WIDTH-1] and diff[WIDTH-1] != a[WIDTH-1].
REQ-024 Results SHALL be registered and held stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-025 In DONE with out_ready=1 at an edge, the FSM SHALL go to IDLE; results SHALL hold their values until overwritten by the next computation.
REQ-026 No operand acceptance SHALL occur in the same edge as result handoff; the minimum initiation interval is N+2 cycles.
REQ-027 in_valid during CALC or DONE SHALL have no effect.
REQ-028 The N=1 case (CHUNK=WIDTH) SHALL use exactly one CALC edge.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, clear the counter, and set diff_out=0, bw_out=0, ovf_out=0, out_valid=0 and in_ready=1.
REQ-030 rst asserted in CALC or DONE SHALL abort the operation with no result emitted; the first accept after rst deasserts SHALL behave as from power-up.

Verification (WIDTH=32, CHUNK=8)
REQ-031 a=5, b=3, bw=0 -> diff=0x00000002, bw_out=0, ovf_out=0; out_valid 5 edges after accept.
REQ-032 a=0, b=1, bw=0 -> diff=0xFFFFFFFF, bw_out=1, ovf_out=0.
REQ-033 a=0x80000000, b=1, bw=0 -> diff=0x7FFFFFFF, bw_out=0, ovf_out=1.
REQ-034 a=0x12345678, b=0x12345678, bw=1 -> diff=0xFFFFFFFF, bw_out=1, ovf_out=0 (checks borrow seeding).
REQ-035 out_ready=0 for 10 cycles in DONE while in_valid=1 with new operands -> outputs unchanged, in_ready=0; after out_ready=1, IDLE then a fresh accept.
REQ-036 rst pulsed on the 2nd CALC edge -> outputs 0 asynchronously, in_ready=1, no out_valid pulse; next operation a=5, b=3 gives diff=2.

Source files
------------

// File: rtl/chunk_subtractor.sv
// Multi-cycle subtractor: computes a - b - bw one CHUNK-bit slice per clock,
// LSB slice first, with a valid/ready handshake on both sides.
module chunk_subtractor #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8   // WIDTH must be a multiple of CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             bw_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] diff_out,
    output logic             bw_out,
    output logic             ovf_out,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned N     = WIDTH / CHUNK;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_bw;
    logic             r_ovf;
    logic [CNT_W-1:0] r_cnt;

    logic             w_last;
    logic [CHUNK-1:0] w_a_slice;
    logic [CHUNK-1:0] w_b_slice;
    logic [CHUNK-1:0] w_d_slice;
    logic [CHUNK:0]   w_sub;
    logic             w_slice_borrow;

    assign w_last = (r_cnt == LAST);

    // Select the current operand slices and subtract with the running borrow.
    always_comb begin
        w_a_slice = '0;
        w_b_slice = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (r_cnt == CNT_W'(k)) begin
                w_a_slice = r_a[k*CHUNK +: CHUNK];
                w_b_slice = r_b[k*CHUNK +: CHUNK];
            end
        end
        // One extra bit catches the borrow out of the slice.
        w_sub          = {1'b0, w_a_slice} - {1'b0, w_b_slice} - {{CHUNK{1'b0}}, r_borrow};
        w_d_slice      = w_sub[CHUNK-1:0];
        w_slice_borrow = w_sub[CHUNK];
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: one CALC edge per slice, DONE waits for out_ready.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (in_valid)  w_state_next = CALC;
            CALC:    if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default:                w_state_next = IDLE;
        endcase
    end

    // Datapath: capture operands on accept, build the result slice by slice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_bw     <= 1'b0;
            r_ovf    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a      <= a_in;
                        r_b      <= b_in;
                        r_borrow <= bw_in;
                        r_cnt    <= '0;
                    end
                end
                CALC: begin
                    for (int k = 0; k < int'(N); k++) begin
                        if (r_cnt == CNT_W'(k)) begin
                            r_diff[k*CHUNK +: CHUNK] <= w_d_slice;
                        end
                    end
                    r_borrow <= w_slice_borrow;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_bw  <= w_slice_borrow;
                        // Signed overflow: operand signs differ and result sign differs from a.
                        r_ovf <= (r_a[WIDTH-1] ^ r_b[WIDTH-1]) &
                                 (w_d_slice[CHUNK-1] ^ r_a[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign diff_out  = r_diff;
    assign bw_out    = r_bw;
    assign ovf_out   = r_ovf;

endmodule

// File: tb/tb_chunk_subtractor.sv
// Self-checking bench for chunk_subtractor (WIDTH=32, CHUNK=8): directed
// corner cases, backpressure, mid-operation reset, then randomized operands.
module tb_chunk_subtractor;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CHUNK = 8;
    localparam int unsigned N     = WIDTH / CHUNK;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             bw_in;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] diff_out;
    logic             bw_out;
    logic             ovf_out;
    logic             out_valid;
    logic             out_ready;

    int n_vec = 0;
    int n_err = 0;

    chunk_subtractor #(
        .WIDTH(WIDTH),
        .CHUNK(CHUNK)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .a_in     (a_in),
        .b_in     (b_in),
        .bw_in    (bw_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .diff_out (diff_out),
        .bw_out   (bw_out),
        .ovf_out  (ovf_out),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (observed=timeout required=finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain wide arithmetic on unsigned and signed interpretations.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic bw,
                         output logic [31:0] d, output logic bo, output logic ov);
        longint unsigned ua;
        longint unsigned ub;
        longint          sa;
        longint          sb;
        longint          sd;
        ua = 64'(a);
        ub = 64'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        d  = 32'(ua - ub - 64'(bw));
        bo = (ua < ub + 64'(bw));
        sd = sa - sb - longint'(bw);
        ov = (sd > SMAX) || (sd < SMIN);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: accept, latency, result, optional backpressure, handoff.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic bw,
                          input int hold);
        logic [31:0] ed;
        logic        eb;
        logic        eo;
        int          lat;
        model(a, b, bw, ed, eb, eo);
        out_ready = 1'b0;
        check("idle_in_ready", in_ready, 1);
        a_in     = a;
        b_in     = b;
        bw_in    = bw;
        in_valid = 1'b1;
        tick();  // accept edge
        // Operands after the accept edge must be ignored.
        in_valid = 1'b0;
        a_in     = $urandom;
        b_in     = $urandom;
        bw_in    = 1'($urandom);
        check("busy_in_ready", in_ready, 0);
        // Edges counted from the accept edge inclusive.
        lat = 0;
        for (int i = 2; i <= 20; i++) begin
            tick();
            if (out_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
        check("latency", lat, N + 1);
        check("diff", diff_out, ed);
        check("bw_out", bw_out, eb);
        check("ovf_out", ovf_out, eo);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            a_in     = $urandom;
            b_in     = $urandom;
            bw_in    = 1'($urandom);
            tick();
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_diff", diff_out, ed);
            check("hold_flags", {bw_out, ovf_out}, {eb, eo});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();  // handoff edge
        out_ready = 1'b0;
        check("post_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
        check("post_diff", diff_out, ed);
    endtask

    initial begin
        int pulses;
        logic [31:0] ra;
        logic [31:0] rb;
        rst       = 1'b0;
        a_in      = '0;
        b_in      = '0;
        bw_in     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_diff", diff_out, 0);
        check("rst_flags", {bw_out, ovf_out}, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Directed corner cases.
        run_op(32'd5, 32'd3, 1'b0, 0);
        run_op(32'd0, 32'd1, 1'b0, 0);
        run_op(32'h8000_0000, 32'd1, 1'b0, 0);
        run_op(32'h1234_5678, 32'h1234_5678, 1'b1, 0);
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0);
        run_op(32'h0000_0100, 32'h0000_0001, 1'b0, 0);

        // Backpressure for 10 cycles with new operands offered.
        run_op(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 10);
        run_op(32'd100, 32'd58, 1'b0, 0);

        // Reset pulsed right after the 2nd CALC edge.
        a_in     = 32'hCAFE_0000;
        b_in     = 32'h0000_1111;
        bw_in    = 1'b1;
        in_valid = 1'b1;
        tick();  // accept
        in_valid = 1'b0;
        tick();  // CALC edge 1
        tick();  // CALC edge 2
        rst = 1'b1;
        #1;
        check("arst_diff", diff_out, 0);
        check("arst_flags", {bw_out, ovf_out}, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_out_valid", out_valid, 0);
        tick();
        rst    = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid === 1'b1) pulses++;
        end
        check("arst_no_pulse", pulses, 0);
        run_op(32'd5, 32'd3, 1'b0, 0);

        // Randomized operands with random backpressure.
        for (int t = 0; t < 24; t++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : 32'($urandom);
            run_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
